// File: rtl/mam_wb_burst_split_if.sv
// Request/write/read handshake bundle shared by both sides of the burst splitter.
// The master modport drives requests and write beats; the slave modport answers them.
interface mam_wb_burst_split_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic                    req_burst;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [13:0]             req_beats;
  logic                    write_valid;
  logic                    write_ready;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;
  logic                    read_valid;
  logic                    read_ready;
  logic [DATA_WIDTH-1:0]   read_data;

  modport master (
    output req_valid, req_rw, req_burst, req_addr, req_beats,
    output write_valid, write_data, write_strb, read_ready,
    input  req_ready, write_ready, read_valid, read_data
  );

  modport slave (
    input  req_valid, req_rw, req_burst, req_addr, req_beats,
    input  write_valid, write_data, write_strb, read_ready,
    output req_ready, write_ready, read_valid, read_data
  );
endinterface

// File: rtl/mam_wb_burst_split.sv
// Splits long MAM memory requests into bursts of at most MAX_BEATS that never
// cross a BOUNDARY-byte line; data beats pass straight through without buffering.
module mam_wb_burst_split #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  parameter int BOUNDARY   = 1024
) (
  input  logic CLK_I,
  input  logic RST_I,
  mam_wb_burst_split_if.slave  s,
  mam_wb_burst_split_if.master m
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  localparam int BOFF_W  = $clog2(BOUNDARY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  rw_q, rw_d;
  logic                  burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [13:0]           remaining_q, remaining_d;
  logic [13:0]           cnt_q, cnt_d;

  logic [BOFF_W:0]       room_bytes;
  logic [31:0]           room_beats;
  logic [31:0]           lim;
  logic [13:0]           chunk;
  logic                  beat_hs;

  // Chunk size depends only on registered state, keeping it off the m_req_ready path.
  always_comb begin
    room_bytes = (BOFF_W+1)'(BOUNDARY) - {1'b0, addr_q[BOFF_W-1:0]};
    room_beats = 32'(room_bytes >> BYTE_SH);
    lim        = (room_beats < 32'(MAX_BEATS)) ? room_beats : 32'(MAX_BEATS);
    if (!burst_q)
      chunk = 14'd1;
    else if (32'(remaining_q) < lim)
      chunk = remaining_q;
    else
      chunk = lim[13:0];
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      burst_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      burst_q     <= burst_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    burst_d       = burst_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    cnt_d         = cnt_q;
    beat_hs       = 1'b0;

    s.req_ready   = 1'b0;
    s.write_ready = 1'b0;
    s.read_valid  = 1'b0;
    s.read_data   = '0;
    m.req_valid   = 1'b0;
    m.req_rw      = 1'b0;
    m.req_burst   = 1'b0;
    m.req_addr    = '0;
    m.req_beats   = '0;
    m.write_valid = 1'b0;
    m.write_data  = '0;
    m.write_strb  = '0;
    m.read_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        s.req_ready = 1'b1;
        if (s.req_valid) begin
          rw_d        = s.req_rw;
          burst_d     = s.req_burst;
          addr_d      = s.req_addr;
          remaining_d = (s.req_beats == 14'd0) ? 14'd1 : s.req_beats;
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        m.req_valid = 1'b1;
        m.req_rw    = rw_q;
        m.req_burst = burst_q && (chunk > 14'd1);
        m.req_addr  = addr_q;
        m.req_beats = chunk;
        if (m.req_ready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (rw_q) begin
          m.write_valid = s.write_valid;
          m.write_data  = s.write_data;
          m.write_strb  = s.write_strb;
          s.write_ready = m.write_ready;
          beat_hs       = s.write_valid && m.write_ready;
        end else begin
          s.read_valid = m.read_valid;
          s.read_data  = m.read_data;
          m.read_ready = s.read_ready;
          beat_hs      = m.read_valid && s.read_ready;
        end
        if (beat_hs) begin
          cnt_d = cnt_q + 14'd1;
          if (cnt_q == chunk - 14'd1) begin
            cnt_d       = '0;
            addr_d      = addr_q + (ADDR_WIDTH'(chunk) << BYTE_SH);
            remaining_d = remaining_q - chunk;
            state_d     = (remaining_q == chunk) ? IDLE : ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mam_wb_burst_split.md
# mam_wb_burst_split

Request-shaping stage directly upstream of the MAM Wishbone master interface. Accepts arbitrary-length memory access requests (up to 16383 beats) from the MAM packet layer and re-issues them as a sequence of bursts. Each burst is at most MAX_BEATS long and never crosses a BOUNDARY-byte address boundary. Write and read data beats are forwarded between the two sides, and each burst's data phase is tracked so the next sub-request is issued only after the current one completes.

## Interface
- DATA_WIDTH, 16: data bits, multiple of 16; BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: address bits.
- MAX_BEATS, 16: maximum beats per issued burst; power of two, 1..8192.
- BOUNDARY, 1024: burst boundary in bytes; power of two, ≥ MAX_BEATS*BYTES.
- CLK_I  in  1  clock; single clock domain.
- RST_I  in  1  reset, asynchronous, active-high.
- s_req_valid / s_req_ready  in / out  1  upstream request handshake.
- s_req_rw  in  1  0 read, 1 write.
- s_req_addr  in  ADDR_WIDTH  byte address, BYTES-aligned.
- s_req_burst  in  1  0 single beat, 1 incremental burst.
- s_req_beats  in  14  total beats; 0 treated as 1.
- s_write_valid / s_write_ready  in / out  1  upstream write beat handshake.
- s_write_data  in  DATA_WIDTH; s_write_strb  in  DATA_WIDTH/8.
- s_read_valid / s_read_ready  out / in  1  upstream read beat handshake.
- s_read_data  out  DATA_WIDTH.
- m_req_valid / m_req_ready  out / in  1  downstream request handshake.
- m_req_rw, m_req_burst  out  1; m_req_addr  out  ADDR_WIDTH; m_req_beats  out  14.
- m_write_valid / m_write_ready  out / in  1; m_write_data  out  DATA_WIDTH; m_write_strb  out  DATA_WIDTH/8.
- m_read_valid / m_read_ready  in / out  1; m_read_data  in  DATA_WIDTH.

## Operation
- Registers: rw, burst, addr (ADDR_WIDTH), remaining (14b), chunk (14b), cnt (14b).
- State IDLE:
  - s_req_ready=1.
  - On s_req_valid, latch the fields; remaining = max(s_req_beats,1); go to ISSUE.
- State ISSUE:
  - m_req_valid=1; m_req_addr=addr; m_req_rw=rw; m_req_beats=chunk.
  - m_req_burst = burst && (chunk>1).
  - chunk = min(remaining, MAX_BEATS, (BOUNDARY − addr mod BOUNDARY)/BYTES); it is 1 if burst=0.
  - Data paths are blocked: m_write_valid=0, s_write_ready=0, m_read_ready=0, s_read_valid=0.
  - On m_req_ready: cnt=0; go to DATA.
- State DATA, write (rw=1):
  - Combinational passthrough: m_write_valid=s_write_valid, m_write_data/strb = s_*, s_write_ready=m_write_ready.
  - On each s_write_valid && m_write_ready: cnt+1.
- State DATA, read (rw=0):
  - Combinational passthrough: s_read_valid=m_read_valid, s_read_data=m_read_data, m_read_ready=s_read_ready.
  - On each m_read_valid && s_read_ready: cnt+1.
- End of a chunk is the handshake where cnt==chunk−1:
  - addr += chunk*BYTES (wraps modulo 2^ADDR_WIDTH); remaining −= chunk.
  - If remaining (new value) ≠ 0, go to ISSUE; else go to IDLE.
- Non-burst requests (s_req_burst=0) with s_req_beats>1 are issued as repeated single-beat requests at consecutive addresses.
- In all states other than those listed above, the data handshake outputs are 0.

## Timing
- Reset (async assert, synchronous deassert at the register level) puts state in IDLE:
  - s_req_ready=1.
  - All other outputs are 0; all registers are 0.
- Request accepted in cycle N gives m_req_valid=1 in cycle N+1; zero latency through the request path is not allowed.
- m_req_* is stable while m_req_valid=1 and m_req_ready=0.
- Data passthrough has zero cycles of latency; the block adds no data buffering.
- Last data handshake of a chunk in cycle M:
  - Next chunk: m_req_valid in M+1.
  - Last chunk: s_req_ready=1 in M+1.
  - Back-to-back upstream requests cost one IDLE cycle.
- chunk is computed combinationally from registered addr/remaining and must not sit on the m_req_ready path.
- RST_I asserted mid-transfer aborts immediately to IDLE; the downstream is reset by the same RST_I.

## Test plan
- Single-beat write: addr 0x100, beats 1, burst 0, data 0xBEEF.
  - Expect one m_req (addr 0x100, beats 1, burst 0) and one write beat 0xBEEF.
  - s_req_ready returns the cycle after the beat.
- Burst write: 40 beats at 0x0 (DATA_WIDTH 16, MAX_BEATS 16).
  - Expect m_req beats 16/16/8 at addresses 0x0/0x20/0x40.
  - All 40 write beats are forwarded in order; no m_write_valid while m_req_valid=1.
- Boundary burst read: 8 beats at 0x3F8 (BOUNDARY 1024).
  - Expect m_req 4 beats @0x3F8, then 4 beats @0x400.
  - 8 read beats are delivered in order.
- Read backpressure: 20-beat read with s_read_ready toggling every other cycle.
  - m_read_ready mirrors s_read_ready; no beat is lost or duplicated.
  - Chunks are 16 then 4.
- Degenerate requests: beats 0 burst 1 → one request, beats 1, burst 0. Non-burst beats 3 at 0x10 → three single requests at 0x10/0x12/0x14.
- Reset mid-burst: assert RST_I after 5 of 16 write beats.
  - All outputs are 0 and s_req_ready=1 during reset.
  - A fresh request after deassert completes normally.
